// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scanner with full-scan debounce and a two-digit BCD entry register.
// Optional build macro KEYPAD_GHOST_REJECT_EN: multi-key scans are never accepted (otherwise the lowest code wins).
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_CYCLES    = 200,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  localparam int DW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int CNTW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [DW-1:0]   C_DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CNTW-1:0] C_DEB        = CNTW'(DEBOUNCE_SCANS);
  localparam logic [CNTW-1:0] C_ONE        = CNTW'(1);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_HELD      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } result_t;

  logic [3:0]      r_rows_meta;
  logic [3:0]      r_rows_sync;
  logic [DW-1:0]   r_dwell;
  logic [1:0]      r_col;
  logic [3:0]      r_cols;
  logic [15:0]     r_scan_map;
  state_t          r_state;
  logic [3:0]      r_cand;
  logic [CNTW-1:0] r_count;
  logic [3:0]      r_key_code;
  logic            r_key_valid;
  logic            r_key_held;
  logic [3:0]      r_tens;
  logic [3:0]      r_ones;

  logic            w_sample;
  logic            w_scan_done;
  logic [15:0]     w_scan_map;
  logic [4:0]      w_hits;
  logic [3:0]      w_low;
  result_t         w_result;
  logic [CNTW-1:0] w_count_inc;
  logic            w_accept;
  logic            w_deb_reached;

  assign w_sample    = (r_dwell == C_DWELL_LAST);
  assign w_scan_done = w_sample && (r_col == 2'd3);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dwell <= '0;
      r_col   <= 2'd0;
      r_cols  <= 4'b1110;
    end else if (w_sample) begin
      r_dwell <= '0;
      r_col   <= r_col + 2'd1;
      r_cols  <= {r_cols[2:0], r_cols[3]};
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Closure map indexed by key code (row*4 + col); the current column is merged in on its sample cycle.
  always_comb begin
    w_scan_map = r_scan_map;
    if (w_sample) begin
      for (int r = 0; r < 4; r++) begin
        if (!r_rows_sync[r]) w_scan_map[r*4 + int'(r_col)] = 1'b1;
      end
    end
  end

  always_comb begin
    w_hits = 5'd0;
    w_low  = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (w_scan_map[i]) begin
        w_hits = w_hits + 5'd1;
        w_low  = 4'(i);
      end
    end
  end

  always_comb begin
    w_result = RES_NONE;
`ifdef KEYPAD_GHOST_REJECT_EN
    if (w_hits == 5'd1)      w_result = RES_KEY;
    else if (w_hits != 5'd0) w_result = RES_MULTI;
`else
    if (w_hits != 5'd0)      w_result = RES_KEY;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_map <= 16'h0000;
    end else if (w_scan_done) begin
      r_scan_map <= 16'h0000;
    end else if (w_sample) begin
      r_scan_map <= w_scan_map;
    end
  end

  assign w_count_inc   = r_count + C_ONE;
  assign w_deb_reached = (w_count_inc == C_DEB);

  always_comb begin
    w_accept = 1'b0;
    if (w_scan_done && (w_result == RES_KEY)) begin
      if (r_state == ST_RELEASED)
        w_accept = (DEBOUNCE_SCANS == 1);
      else if (r_state == ST_CANDIDATE)
        w_accept = (w_low == r_cand) && w_deb_reached;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_RELEASED;
      r_cand      <= 4'd0;
      r_count     <= '0;
      r_key_code  <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_accept) begin
        r_state     <= ST_HELD;
        r_count     <= '0;
        r_key_code  <= w_low;
        r_key_valid <= 1'b1;
        r_key_held  <= 1'b1;
        if (w_low <= 4'd9) begin
          r_tens <= r_ones;
          r_ones <= w_low;
        end else if (w_low == 4'd12) begin
          r_tens <= 4'd0;
          r_ones <= 4'd0;
        end
      end else if (w_scan_done) begin
        unique case (r_state)
          ST_RELEASED: begin
            if (w_result == RES_KEY) begin
              r_state <= ST_CANDIDATE;
              r_cand  <= w_low;
              r_count <= C_ONE;
            end
          end
          ST_CANDIDATE: begin
            if (w_result != RES_KEY) begin
              r_state <= ST_RELEASED;
              r_count <= '0;
            end else if (w_low == r_cand) begin
              r_count <= w_count_inc;
            end else begin
              r_cand  <= w_low;
              r_count <= C_ONE;
            end
          end
          ST_HELD: begin
            // Any closure, including a ghosted multi-press, restarts the release debounce.
            if (w_result != RES_NONE) begin
              r_count <= '0;
            end else if (w_deb_reached) begin
              r_state    <= ST_RELEASED;
              r_count    <= '0;
              r_key_held <= 1'b0;
            end else begin
              r_count <= w_count_inc;
            end
          end
          default: begin
            r_state <= ST_RELEASED;
            r_count <= '0;
          end
        endcase
      end
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign tens      = r_tens;
  assign ones      = r_ones;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_SCANS=2.
`default_nettype none

module tb_keypad_scanner;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [3:0]  tens;
  logic [3:0]  ones;

  logic [15:0] pressed = 16'h0000;
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;

  keypad_scanner #(
    .SCAN_CYCLES   (4),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .tens     (tens),
    .ones     (ones)
  );

  always #5 clock = ~clock;

  // Physical keypad: a closed key pulls its row low while its column is driven low.
  always @* begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clock) if (key_valid) valid_cnt++;

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    pressed = 16'h0000;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    valid_cnt = 0;
  endtask

  task automatic press_for(input int code, input int n);
    pressed = 16'h0000;
    pressed[code] = 1'b1;
    cycles(n);
    pressed = 16'h0000;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL reset_cols got %b want 1110", cols); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
    checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL reset_bcd got %0d%0d want 00", tens, ones); end
  endtask

  task automatic test_idle();
    logic [3:0] exp;
    do_reset();
    #1;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) cycles(1);
      exp = 4'b1111;
      exp[(i / 4) % 4] = 1'b0;
      checks++; if (cols !== exp) begin errors++; $display("FAIL idle_cols cycle %0d got %b want %b", i, cols, exp); end
    end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL idle_valid got %0d want 0", valid_cnt); end
    checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL idle_bcd got %0d%0d want 00", tens, ones); end
  endtask

  task automatic test_single_press();
    do_reset();
    pressed[6] = 1'b1;
    cycles(48);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL press6_valid_count got %0d want 1", valid_cnt); end
    checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL press6_code got %0d want 6", key_code); end
    checks++; if (ones !== 4'd6 || tens !== 4'd0) begin errors++; $display("FAIL press6_bcd got %0d%0d want 06", tens, ones); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press6_held got %b want 1", key_held); end
    pressed = 16'h0000;
    cycles(48);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release6_held got %b want 0", key_held); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL release6_valid_count got %0d want 1", valid_cnt); end
  endtask

  task automatic test_digit_entry();
    do_reset();
    press_for(4, 48); cycles(48);
    press_for(2, 48); cycles(48);
    checks++; if (tens !== 4'd4 || ones !== 4'd2) begin errors++; $display("FAIL entry42 got %0d%0d want 42", tens, ones); end
    press_for(11, 48); cycles(48);
    checks++; if (key_code !== 4'd11 || tens !== 4'd4 || ones !== 4'd2) begin
      errors++; $display("FAIL entry_code11 got code %0d bcd %0d%0d want code 11 bcd 42", key_code, tens, ones);
    end
    press_for(12, 48); cycles(48);
    checks++; if (tens !== 4'd0 || ones !== 4'd0) begin errors++; $display("FAIL entry_clear got %0d%0d want 00", tens, ones); end
    checks++; if (valid_cnt !== 4) begin errors++; $display("FAIL entry_valid_count got %0d want 4", valid_cnt); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pressed = 16'h0020;
      cycles(16);
      pressed = 16'h0000;
      cycles(16);
    end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL bounce_valid got %0d want 0", valid_cnt); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held got %b want 0", key_held); end
  endtask

  task automatic test_multi_press();
    do_reset();
    pressed = 16'h0208;
    cycles(64);
    pressed = 16'h0000;
`ifdef KEYPAD_GHOST_REJECT_EN
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL multi_valid got %0d want 0", valid_cnt); end
`else
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL multi_valid got %0d want 1", valid_cnt); end
    checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL multi_code got %0d want 3", key_code); end
`endif
    cycles(48);
  endtask

  task automatic test_reset_mid_debounce();
    int first;
    bit found;
    do_reset();
    press_for(8, 48); cycles(48);
    checks++; if (ones !== 4'd8) begin errors++; $display("FAIL pre_reset_ones got %0d want 8", ones); end
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      cycles(1);
      if (cols === 4'b1110 && dut.r_dwell == 0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL align_timeout got 0 want 1"); end
    pressed[7] = 1'b1;
    cycles(20);
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    checks++; if (cols !== 4'b1110 || key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs got cols %b held %b valid %b want 1110 0 0", cols, key_held, key_valid);
    end
    checks++; if (ones !== 4'd0 || tens !== 4'd0) begin errors++; $display("FAIL midreset_bcd got %0d%0d want 00", tens, ones); end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    valid_cnt = 0;
    first = -1;
    for (int c = 1; c <= 40; c++) begin
      cycles(1);
      if (key_valid === 1'b1 && first < 0) first = c;
    end
    checks++; if (first !== 32) begin errors++; $display("FAIL postreset_latency got %0d want 32", first); end
    checks++; if (valid_cnt !== 1 || key_code !== 4'd7 || ones !== 4'd7) begin
      errors++; $display("FAIL postreset_key got count %0d code %0d ones %0d want 1 7 7", valid_cnt, key_code, ones);
    end
    pressed = 16'h0000;
    cycles(48);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_press();
    test_digit_entry();
    test_bounce();
    test_multi_press();
    test_reset_mid_debounce();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 200: clock cycles each column is driven before advancing (at least 4).
REQ-002 Parameter DEBOUNCE_SCANS, default 4: consecutive identical full-scan results needed to accept a press or a release (at least 1).
REQ-003 clock  input  1  single system clock; all state SHALL update on the rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 rows  input  4  keypad row lines, active-low (pulled up; 0 = key closed), asynchronous to clock.
REQ-006 cols  output  4  keypad column drive, active-low, exactly one bit low at any time.
REQ-007 key_code  output  4  code of last accepted key, code = row_index*4 + col_index.
REQ-008 key_valid  output  1  single-cycle strobe, high in the cycle key_code updates.
REQ-009 key_held  output  1  high while an accepted key has not yet been released.
REQ-010 tens  output  4  BCD tens digit of entered value, feeds display tens input.
REQ-011 ones  output  4  BCD ones digit of entered value, feeds display ones input.

Function
REQ-012 rows SHALL pass through a 2-flop synchronizer before any use.
REQ-013 Column counter SHALL cycle cols 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing every SCAN_CYCLES cycles; a full scan is 4*SCAN_CYCLES cycles.
REQ-014 Synchronized rows SHALL be sampled once per column, in the last dwell cycle of that column (dwell count = SCAN_CYCLES-1).
REQ-015 At the end of each full scan, a scan result SHALL be formed: NONE (no closures), KEY(k) (exactly one closure), or MULTI (two or more closures).
REQ-016 Press FSM states: RELEASED, CANDIDATE, HELD; reset state RELEASED.
REQ-017 RELEASED: KEY(k) -> CANDIDATE, cand=k, count=1; NONE or MULTI -> stay.
REQ-018 CANDIDATE: KEY(cand) -> count+1; KEY(j), j!=cand -> cand=j, count=1; NONE or MULTI -> RELEASED.
REQ-019 When count reaches DEBOUNCE_SCANS (immediately if DEBOUNCE_SCANS=1): key_code=cand, key_valid=1 for one cycle, key_held=1, next state HELD.
REQ-020 HELD: NONE for DEBOUNCE_SCANS consecutive scans -> RELEASED, key_held=0; any KEY or MULTI result SHALL reset the release count; no further key_valid while HELD (no auto-repeat).
REQ-021 On key_valid with key_code 0-9: tens<=ones, ones<=key_code (shift-in).
REQ-022 On key_valid with key_code 12 (C): tens<=0, ones<=0.
REQ-023 Other codes (10, 11, 13, 14, 15) SHALL update key_code and key_valid only; tens and ones unchanged.
REQ-024 tens and ones SHALL always hold values 0-9.

Reset
REQ-025 On reset_n low, asynchronously: cols=1110, key_code=0, key_valid=0, key_held=0, tens=0, ones=0, FSM=RELEASED, all counters and synchronizer flops 0/idle (sync flops to 1111).
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard the pending press; no key_valid is emitted after release of reset until a full new debounce completes.

Configuration
REQ-027 Macro KEYPAD_GHOST_REJECT_EN defined: MULTI results handled per REQ-017/018/020 (a multi-press is never accepted).
REQ-028 Macro KEYPAD_GHOST_REJECT_EN undefined: MULTI SHALL be reduced to KEY(k) with k the lowest code among the closures, and MULTI never occurs.

Verification (SCAN_CYCLES=4, DEBOUNCE_SCANS=2)
REQ-029 Reset then idle: cols rotates 1110, 1101, 1011, 0111 with 4 cycles each; key_valid never asserts; tens=ones=0.
REQ-030 Hold row1/col2 (code 6) for 3 scans: exactly one key_valid, key_code=6, ones=6, tens=0, key_held=1; release for 2 scans: key_held=0.
REQ-031 Press 4, release, then press 2: tens=4, ones=2; then press code 12: tens=0, ones=0.
REQ-032 Bounce: key 5 closed for 1 scan, open 1 scan, repeated 5 times: no key_valid.
REQ-033 Keys 3 and 9 held together for 4 scans: with KEYPAD_GHOST_REJECT_EN no key_valid; without it one key_valid with key_code=3.
REQ-034 reset_n pulsed low after the first matching scan of key 7, key held throughout: outputs at reset values, then key_valid with key_code=7 exactly 2 full scans after reset release.
